// File: rtl/riscv_pkg.sv
// Shared definitions for the riscv_core control path.
//   - RV32I base opcode constants (OP_*)
//   - ctrl_state_e : sequencer states
//   - pc_sel_e     : PC source select (PC+4, PC+imm, (rs1+imm)&~1)
//   - wb_sel_e     : register write-back source select
//   - opc_class_e  : decoded instruction class used by the sequencer
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_SYS    = 7'h73;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_JALR  = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_SYS,
    CLS_ILLEGAL
  } opc_class_e;

endpackage

// File: rtl/riscv_ctrl_fsm_if.sv
// Control bus between the sequencer (master) and the riscv_core datapath (slave).
//   opcode/funct3   : fields of the instruction register
//   branch_taken    : ALU compare result, valid in EXEC
//   ir_we, pc_we    : IR capture / PC update strobes
//   pc_sel          : 00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
//   alu_a_sel       : 0 rs1, 1 PC
//   alu_b_sel       : 0 rs2, 1 imm
//   wb_sel          : 00 ALU, 01 load data, 10 PC+4
//   rd_we           : regfile write strobe
//   mem_write_en    : data memory write strobe
interface riscv_ctrl_fsm_if;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       branch_taken;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       alu_a_sel;
  logic       alu_b_sel;
  logic [1:0] wb_sel;
  logic       rd_we;
  logic       mem_write_en;

  modport master (
    input  opcode, funct3, branch_taken,
    output ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, wb_sel, rd_we, mem_write_en
  );

  modport slave (
    output opcode, funct3, branch_taken,
    input  ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, wb_sel, rd_we, mem_write_en
  );

endinterface

// File: rtl/riscv_ctrl_decode.sv
// Combinational opcode-to-class decoder for the control sequencer.
//   opcode  : inst[6:0] from the IR
//   cls     : decoded instruction class
//   illegal : opcode is not one of the supported RV32I classes
module riscv_ctrl_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output opc_class_e cls,
  output logic       illegal
);

  always_comb begin
    cls = CLS_ILLEGAL;
    unique case (opcode)
      OP_R:      cls = CLS_R;
      OP_I:      cls = CLS_I;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_JAL:    cls = CLS_JAL;
      OP_JALR:   cls = CLS_JALR;
      OP_LUI:    cls = CLS_LUI;
      OP_AUIPC:  cls = CLS_AUIPC;
      OP_SYS:    cls = CLS_SYS;
      default:   cls = CLS_ILLEGAL;
    endcase
    illegal = (cls == CLS_ILLEGAL);
  end

endmodule

// File: rtl/riscv_ctrl_fsm.sv
// Multi-cycle control sequencer for riscv_core: FETCH/DECODE/EXEC/MEM/WB with a
// sticky HALT on ECALL/illegal opcode.
//   clk, rst_b   : clock; synchronous active-high reset (rst_b=1 resets)
//   bus          : control bus (master modport), see riscv_ctrl_fsm_if
//   retire       : one-cycle pulse per completed instruction
//   illegal      : sticky, halted on unknown opcode
//   halted       : sticky halt
//   cycle_cnt    : cycle counter   (RISCV_CTRL_PERF_CNT_EN, else 0)
//   instret_cnt  : retire counter  (RISCV_CTRL_PERF_CNT_EN, else 0)
// Optional feature macro: RISCV_CTRL_PERF_CNT_EN
module riscv_ctrl_fsm
  import riscv_pkg::*;
#(
  parameter int unsigned FETCH_LAT = 1,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_b,
  riscv_ctrl_fsm_if.master      bus,
  output logic                  retire,
  output logic                  illegal,
  output logic                  halted,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      instret_cnt
);

  localparam int unsigned LAT_MAX = (FETCH_LAT > MEM_LAT) ? FETCH_LAT : MEM_LAT;
  localparam int unsigned WCNT_W  = $clog2(LAT_MAX + 1);
  localparam logic [WCNT_W-1:0] FETCH_LAST = WCNT_W'(FETCH_LAT - 1);
  localparam logic [WCNT_W-1:0] MEM_LAST   = WCNT_W'(MEM_LAT - 1);

  ctrl_state_e       state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              illegal_q, illegal_d;

  opc_class_e cls;
  logic       dec_illegal;

  logic       ir_we, pc_we, alu_a_sel, alu_b_sel, rd_we, mem_write_en, retire_c;
  logic [1:0] pc_sel, wb_sel;

  // funct3 only matters to the datapath (access width, compare type).
  logic unused_funct3;
  assign unused_funct3 = ^bus.funct3;

  riscv_ctrl_decode u_decode (
    .opcode  (bus.opcode),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q   <= ST_FETCH;
      wcnt_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      illegal_q <= illegal_d;
    end
  end

  // wcnt counts up from 0 inside FETCH/MEM; every other state leaves it at 0,
  // so entering FETCH or MEM always starts from a fresh count.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = '0;
    illegal_d    = illegal_q;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    wb_sel       = WB_ALU;
    rd_we        = 1'b0;
    mem_write_en = 1'b0;
    retire_c     = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        if (wcnt_q == FETCH_LAST) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end

      ST_DECODE: begin
        if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else if (cls == CLS_SYS) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        unique case (cls)
          CLS_R: ;
          CLS_I, CLS_LOAD, CLS_STORE, CLS_JALR: alu_b_sel = 1'b1;
          CLS_AUIPC, CLS_JAL, CLS_BRANCH: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
          end
          CLS_LUI: alu_b_sel = 1'b1;
          default: ;
        endcase
        if (cls == CLS_BRANCH) begin
          pc_we    = 1'b1;
          pc_sel   = bus.branch_taken ? PC_IMM : PC_PLUS4;
          retire_c = 1'b1;
          state_d  = ST_FETCH;
        end else if (cls == CLS_LOAD || cls == CLS_STORE) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        alu_b_sel = 1'b1;
        if (cls == CLS_STORE && wcnt_q == '0) mem_write_en = 1'b1;
        if (wcnt_q == MEM_LAST) begin
          if (cls == CLS_STORE) begin
            pc_we    = 1'b1;
            retire_c = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end

      ST_WB: begin
        rd_we    = 1'b1;
        pc_we    = 1'b1;
        retire_c = 1'b1;
        state_d  = ST_FETCH;
        unique case (cls)
          CLS_LOAD: wb_sel = WB_MEM;
          CLS_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = PC_IMM;
          end
          CLS_JALR: begin
            wb_sel = WB_PC4;
            pc_sel = PC_JALR;
          end
          default: ;
        endcase
      end

      ST_HALT: ;

      default: state_d = ST_FETCH;
    endcase

    // Outputs are state-decoded, so mask them while reset is held; otherwise
    // FETCH with FETCH_LAT=1 would strobe ir_we during reset.
    if (rst_b) begin
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = PC_PLUS4;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 1'b0;
      wb_sel       = WB_ALU;
      rd_we        = 1'b0;
      mem_write_en = 1'b0;
      retire_c     = 1'b0;
    end
  end

  assign bus.ir_we        = ir_we;
  assign bus.pc_we        = pc_we;
  assign bus.pc_sel       = pc_sel;
  assign bus.alu_a_sel    = alu_a_sel;
  assign bus.alu_b_sel    = alu_b_sel;
  assign bus.wb_sel       = wb_sel;
  assign bus.rd_we        = rd_we;
  assign bus.mem_write_en = mem_write_en;
  assign retire           = retire_c;
  assign illegal          = illegal_q;
  assign halted           = (state_q == ST_HALT);

`ifdef RISCV_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q != ST_HALT) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    if (retire_c)           instret_cnt_d = instret_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Directed bench for riscv_ctrl_fsm. Three instances share one stimulus:
// MEM_LAT=1 (u_dut), MEM_LAT=3 (u_dut_m3), MEM_LAT=2 (u_dut_m2).
module tb_riscv_ctrl_fsm;

  localparam int unsigned CW = 32;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [6:0] op;
  logic [2:0] f3;
  logic       bt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  riscv_ctrl_fsm_if if0 ();
  riscv_ctrl_fsm_if if3 ();
  riscv_ctrl_fsm_if if2 ();

  assign if0.opcode = op;  assign if0.funct3 = f3;  assign if0.branch_taken = bt;
  assign if3.opcode = op;  assign if3.funct3 = f3;  assign if3.branch_taken = bt;
  assign if2.opcode = op;  assign if2.funct3 = f3;  assign if2.branch_taken = bt;

  logic          ret0, ill0, halt0, ret3, ill3, halt3, ret2, ill2, halt2;
  logic [CW-1:0] cyc0, ins0, cyc3, ins3, cyc2, ins2;

  riscv_ctrl_fsm #(.FETCH_LAT(1), .MEM_LAT(1), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_b(rst_b), .bus(if0), .retire(ret0), .illegal(ill0),
    .halted(halt0), .cycle_cnt(cyc0), .instret_cnt(ins0)
  );
  riscv_ctrl_fsm #(.FETCH_LAT(1), .MEM_LAT(3), .CNT_W(CW)) u_dut_m3 (
    .clk(clk), .rst_b(rst_b), .bus(if3), .retire(ret3), .illegal(ill3),
    .halted(halt3), .cycle_cnt(cyc3), .instret_cnt(ins3)
  );
  riscv_ctrl_fsm #(.FETCH_LAT(1), .MEM_LAT(2), .CNT_W(CW)) u_dut_m2 (
    .clk(clk), .rst_b(rst_b), .bus(if2), .retire(ret2), .illegal(ill2),
    .halted(halt2), .cycle_cnt(cyc2), .instret_cnt(ins2)
  );

  // Packed control word: {ir_we, pc_we, pc_sel, a_sel, b_sel, wb_sel, rd_we, mem_we, retire, halted, illegal}
  logic [12:0] obs0, obs3, obs2;
  assign obs0 = {if0.ir_we, if0.pc_we, if0.pc_sel, if0.alu_a_sel, if0.alu_b_sel, if0.wb_sel,
                 if0.rd_we, if0.mem_write_en, ret0, halt0, ill0};
  assign obs3 = {if3.ir_we, if3.pc_we, if3.pc_sel, if3.alu_a_sel, if3.alu_b_sel, if3.wb_sel,
                 if3.rd_we, if3.mem_write_en, ret3, halt3, ill3};
  assign obs2 = {if2.ir_we, if2.pc_we, if2.pc_sel, if2.alu_a_sel, if2.alu_b_sel, if2.wb_sel,
                 if2.rd_we, if2.mem_write_en, ret2, halt2, ill2};

  function automatic logic [12:0] ctl(input logic ir, input logic pcwe, input logic [1:0] pcs,
                                      input logic a, input logic b, input logic [1:0] wb,
                                      input logic rd, input logic mw, input logic ret,
                                      input logic h, input logic il);
    return {ir, pcwe, pcs, a, b, wb, rd, mw, ret, h, il};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_ctl(input int which, input string tag, input logic [12:0] exp);
    logic [12:0] got;
    case (which)
      3:       got = obs3;
      2:       got = obs2;
      default: got = obs0;
    endcase
    check_eq(tag, {51'd0, got}, {51'd0, exp});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Holds reset 3 cycles, checks the masked outputs, releases. Returns in cycle 1.
  task automatic reset_dut(input int which, input string tag);
    rst_b = 1'b1;
    repeat (3) next_cycle();
    check_ctl(which, {tag, " reset"}, 13'd0);
    rst_b = 1'b0;
    #0;
  endtask

  // Checks one expected control word per cycle, advancing after each.
  task automatic run_seq(input int which, input string tag, input logic [12:0] seq[$]);
    foreach (seq[i]) begin
      check_ctl(which, $sformatf("%s c%0d", tag, i + 1), seq[i]);
      next_cycle();
    end
  endtask

  logic [12:0] IDLE, IRW, EX_RS1_IMM, EX_PC_IMM, MEM_B, WB_ALU_W, WB_LD_W;
  logic [12:0] ST_WR, ST_DONE, BR_T, BR_N, HLT, HLT_ILL;
  logic [12:0] seq[$];
  logic [CW-1:0] exp_cyc, exp_ins;

  initial begin
    IDLE       = ctl(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    IRW        = ctl(1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    EX_RS1_IMM = ctl(0, 0, 2'b00, 0, 1, 2'b00, 0, 0, 0, 0, 0);
    EX_PC_IMM  = ctl(0, 0, 2'b00, 1, 1, 2'b00, 0, 0, 0, 0, 0);
    MEM_B      = ctl(0, 0, 2'b00, 0, 1, 2'b00, 0, 0, 0, 0, 0);
    WB_ALU_W   = ctl(0, 1, 2'b00, 0, 0, 2'b00, 1, 0, 1, 0, 0);
    WB_LD_W    = ctl(0, 1, 2'b00, 0, 0, 2'b01, 1, 0, 1, 0, 0);
    ST_WR      = ctl(0, 0, 2'b00, 0, 1, 2'b00, 0, 1, 0, 0, 0);
    ST_DONE    = ctl(0, 1, 2'b00, 0, 1, 2'b00, 0, 0, 1, 0, 0);
    BR_T       = ctl(0, 1, 2'b01, 1, 1, 2'b00, 0, 0, 1, 0, 0);
    BR_N       = ctl(0, 1, 2'b00, 1, 1, 2'b00, 0, 0, 1, 0, 0);
    HLT        = ctl(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    HLT_ILL    = ctl(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 1);

    rst_b = 1'b1;
    f3    = 3'd0;
    bt    = 1'b0;

    // addi x1,x0,5 (0x00500093): 4 cycles
    op = 7'h13;
    reset_dut(0, "addi");
    seq = '{IRW, IDLE, EX_RS1_IMM, WB_ALU_W, IRW};
    run_seq(0, "addi", seq);

    // lw 0x0000A103, MEM_LAT=3: MEM in cycles 4-6, WB in cycle 7
    op = 7'h03; f3 = 3'd2;
    reset_dut(3, "load");
    seq = '{IRW, IDLE, EX_RS1_IMM, MEM_B, MEM_B, MEM_B, WB_LD_W, IRW};
    run_seq(3, "load", seq);

    // sw 0x0020A023, MEM_LAT=2: write in cycle 4 only, retire in cycle 5
    op = 7'h23; f3 = 3'd2;
    reset_dut(2, "store");
    seq = '{IRW, IDLE, EX_RS1_IMM, ST_WR, ST_DONE, IRW};
    run_seq(2, "store", seq);

    // beq 0x00208463 taken, then not taken back to back
    op = 7'h63; f3 = 3'd0; bt = 1'b1;
    reset_dut(0, "br");
    seq = '{IRW, IDLE, BR_T};
    run_seq(0, "br_taken", seq);
    bt = 1'b0;
    seq = '{IRW, IDLE, BR_N, IRW};
    run_seq(0, "br_not", seq);

    // AUIPC uses PC+imm in EXEC
    op = 7'h17;
    reset_dut(0, "auipc");
    seq = '{IRW, IDLE, EX_PC_IMM, WB_ALU_W};
    run_seq(0, "auipc", seq);

    // ECALL: halted from cycle 3, sticky for 20 cycles with no strobes
    op = 7'h73;
    reset_dut(0, "ecall");
    seq = '{IRW, IDLE};
    for (int i = 0; i < 20; i++) seq.push_back(HLT);
    run_seq(0, "ecall", seq);
    reset_dut(0, "ecall_clr");
    check_eq("ecall_clr halted", {63'd0, halt0}, 64'd0);

    // illegal opcode 0x7F
    op = 7'h7F;
    seq = '{IRW, IDLE, HLT_ILL, HLT_ILL, HLT_ILL, HLT_ILL};
    run_seq(0, "illegal", seq);
    reset_dut(0, "ill_clr");
    check_eq("ill_clr illegal", {63'd0, ill0}, 64'd0);
    check_eq("ill_clr halted", {63'd0, halt0}, 64'd0);

    // 10 x addi then ECALL: 40 + 2 counted cycles, 10 retirements
`ifdef RISCV_CTRL_PERF_CNT_EN
    exp_cyc = CW'(42);
    exp_ins = CW'(10);
`else
    exp_cyc = '0;
    exp_ins = '0;
`endif
    op = 7'h13;
    reset_dut(0, "perf");
    repeat (40) next_cycle();
    op = 7'h73;
    repeat (2) next_cycle();
    check_eq("perf halted", {63'd0, halt0}, 64'd1);
    check_eq("perf cycle_cnt", {32'd0, cyc0}, {32'd0, exp_cyc});
    check_eq("perf instret_cnt", {32'd0, ins0}, {32'd0, exp_ins});
    repeat (10) next_cycle();
    check_eq("perf cycle_cnt frozen", {32'd0, cyc0}, {32'd0, exp_cyc});
    check_eq("perf instret_cnt frozen", {32'd0, ins0}, {32'd0, exp_ins});

    // reset asserted in the middle of a LOAD's MEM phase (MEM_LAT=3, cycle 5)
    op = 7'h03; f3 = 3'd2;
    reset_dut(3, "ldabort");
    seq = '{IRW, IDLE, EX_RS1_IMM, MEM_B};
    run_seq(3, "ldabort", seq);
    rst_b = 1'b1;
    #1;
    check_ctl(3, "ldabort masked", IDLE);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_ctl(3, $sformatf("ldabort hold%0d", i), IDLE);
    end
    check_eq("ldabort cycle_cnt", {32'd0, cyc3}, 64'd0);
    check_eq("ldabort instret_cnt", {32'd0, ins3}, 64'd0);
    rst_b = 1'b0;
    #0;
    seq = '{IRW, IDLE, EX_RS1_IMM};
    run_seq(3, "ldrestart", seq);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
